// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display path: glyph table, digit
// selects, capture FSM encoding and the glyph-to-nibble decode function.
package seg_pkg;

   localparam logic [6:0] GLYPH_0 = 7'h3F;
   localparam logic [6:0] GLYPH_1 = 7'h06;
   localparam logic [6:0] GLYPH_2 = 7'h5B;
   localparam logic [6:0] GLYPH_3 = 7'h4F;
   localparam logic [6:0] GLYPH_4 = 7'h66;
   localparam logic [6:0] GLYPH_5 = 7'h6D;
   localparam logic [6:0] GLYPH_6 = 7'h7D;
   localparam logic [6:0] GLYPH_7 = 7'h07;
   localparam logic [6:0] GLYPH_8 = 7'h7F;
   localparam logic [6:0] GLYPH_9 = 7'h6F;
   localparam logic [6:0] GLYPH_A = 7'h77;
   localparam logic [6:0] GLYPH_B = 7'h7C;
   localparam logic [6:0] GLYPH_C = 7'h39;
   localparam logic [6:0] GLYPH_D = 7'h5E;
   localparam logic [6:0] GLYPH_E = 7'h79;
   localparam logic [6:0] GLYPH_F = 7'h71;

   // Element [n] is the glyph for nibble n.
   localparam logic [15:0][6:0] GLYPH_TABLE = {
      GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
      GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
   };

   localparam logic [5:0] DIG_BLANK = 6'b000000;
   localparam logic [5:0] DIG_HI    = 6'b000001;
   localparam logic [5:0] DIG_LO    = 6'b000010;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_GOT_LO,
      ST_GOT_HI
   } cap_state_t;

   typedef enum logic [1:0] {
      DC_BLANK,
      DC_LO,
      DC_HI,
      DC_BAD
   } dig_class_t;

   // Returns {ok, nibble}; ok is low for a lit decimal point or an unknown pattern.
   function automatic logic [4:0] glyph_to_nibble(input logic [7:0] seg);
      logic [4:0] res;
      res = 5'b0_0000;
      for (int i = 0; i < 16; i++) begin
         if (!seg[7] && (seg[6:0] == GLYPH_TABLE[i])) begin
            res = {1'b1, 4'(i)};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/seg_glyph_dec.sv
// Combinational segment-pattern decoder: 8-bit segment bus to {ok, nibble}.
module seg_glyph_dec
   import seg_pkg::*;
(
   input  logic [7:0] seg,
   output logic       ok,
   output logic [3:0] nibble
);

   assign {ok, nibble} = glyph_to_nibble(seg);

endmodule

// File: rtl/seg_capture.sv
// Reconstructs the byte shown on a two-digit multiplexed seven-segment bus,
// flagging protocol/glyph errors and a stale (idle) bus.
module seg_capture
   import seg_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_seg,
   input  logic [5:0] i_dig,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_changed,
   output logic       o_err,
   output logic [7:0] o_err_cnt,
   output logic       o_stale
);

   localparam logic [15:0] TIMEOUT_Q = 16'(TIMEOUT);

   logic [7:0]  seg_q;
   logic [5:0]  dig_q;
   logic        glyph_ok;
   logic [3:0]  nibble;
   dig_class_t  dig_class;
   cap_state_t  state;
   logic [3:0]  lo_q;
   logic [3:0]  hi_q;
   logic [15:0] idle_cnt;
   logic        good_digit;
   logic        timeout_hit;
   logic [7:0]  byte_lo_first;
   logic [7:0]  byte_hi_first;

   seg_glyph_dec u_glyph_dec (
      .seg    (seg_q),
      .ok     (glyph_ok),
      .nibble (nibble)
   );

   // NOTE: assign a default first so every path drives dig_class and no latch is inferred.
   always_comb begin
      dig_class = DC_BAD;
      case (dig_q)
         DIG_BLANK: dig_class = DC_BLANK;
         DIG_LO:    dig_class = DC_LO;
         DIG_HI:    dig_class = DC_HI;
         default:   dig_class = DC_BAD;
      endcase
   end

   assign good_digit    = glyph_ok && ((dig_class == DC_LO) || (dig_class == DC_HI));
   // Counter saturates at TIMEOUT, so ">= TIMEOUT-1" means the next value is TIMEOUT.
   assign timeout_hit   = !good_digit && (idle_cnt >= (TIMEOUT_Q - 16'd1));
   assign byte_lo_first = {nibble, lo_q};
   assign byte_hi_first = {hi_q, nibble};

   // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         seg_q     <= 8'h00;
         dig_q     <= DIG_BLANK;
         state     <= ST_EMPTY;
         lo_q      <= 4'h0;
         hi_q      <= 4'h0;
         idle_cnt  <= 16'd0;
         o_data    <= 8'h00;
         o_valid   <= 1'b0;
         o_changed <= 1'b0;
         o_err     <= 1'b0;
         o_err_cnt <= 8'd0;
         o_stale   <= 1'b0;
      end else begin
         seg_q     <= i_seg;
         dig_q     <= i_dig;
         o_valid   <= 1'b0;
         o_changed <= 1'b0;
         o_err     <= 1'b0;

         if (good_digit) begin
            idle_cnt <= 16'd0;
         end else if (idle_cnt != TIMEOUT_Q) begin
            idle_cnt <= idle_cnt + 16'd1;
         end

         if ((dig_class == DC_BAD) ||
             (((dig_class == DC_LO) || (dig_class == DC_HI)) && !glyph_ok)) begin
            o_err <= 1'b1;
            if (o_err_cnt != 8'hFF) begin
               o_err_cnt <= o_err_cnt + 8'd1;
            end
            state <= ST_EMPTY;
         end else if (dig_class == DC_LO) begin
            if (state == ST_GOT_HI) begin
               o_data    <= byte_hi_first;
               o_valid   <= 1'b1;
               o_changed <= (byte_hi_first != o_data);
               o_stale   <= 1'b0;
               state     <= ST_EMPTY;
            end else begin
               lo_q  <= nibble;
               state <= ST_GOT_LO;
            end
         end else if (dig_class == DC_HI) begin
            if (state == ST_GOT_LO) begin
               o_data    <= byte_lo_first;
               o_valid   <= 1'b1;
               o_changed <= (byte_lo_first != o_data);
               o_stale   <= 1'b0;
               state     <= ST_EMPTY;
            end else begin
               hi_q  <= nibble;
               state <= ST_GOT_HI;
            end
         end

         // Placed last so it overrides the state update above; never true on a good digit.
         if (timeout_hit) begin
            o_stale <= 1'b1;
            state   <= ST_EMPTY;
         end
      end
   end

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture: scoreboard of expected bytes checked against
// the valid pulses seen on the output bus.
module tb_seg_capture;

   localparam int unsigned TIMEOUT = 16;
   localparam logic [5:0] D_LO    = 6'b000010;
   localparam logic [5:0] D_HI    = 6'b000001;
   localparam logic [5:0] D_BLANK = 6'b000000;

   typedef struct {
      logic [7:0] data;
      logic       changed;
      int         cyc;
   } out_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] seg;
   logic [5:0] dig;
   logic [7:0] data;
   logic       valid;
   logic       changed;
   logic       err;
   logic [7:0] err_cnt;
   logic       stale;

   out_t       exp_q[$];
   out_t       obs_q[$];
   out_t       mon_o;
   out_t       exp_e;
   out_t       obs_o;
   int         obs_rd = 0;
   int         cyc = 0;
   int         err_seen = 0;
   int         both_seen = 0;
   int         tests = 0;
   int         fails = 0;
   int         err0;
   logic [7:0] model_data = 8'h00;
   logic [5:0] bad_digs [4] = '{6'b000011, 6'b000100, 6'b100000, 6'b111111};

   always #5 clk = ~clk;

   seg_capture #(.TIMEOUT(TIMEOUT)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_seg     (seg),
      .i_dig     (dig),
      .o_data    (data),
      .o_valid   (valid),
      .o_changed (changed),
      .o_err     (err),
      .o_err_cnt (err_cnt),
      .o_stale   (stale)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid) begin
         mon_o.data    = data;
         mon_o.changed = changed;
         mon_o.cyc     = cyc;
         obs_q.push_back(mon_o);
      end
      if (err) err_seen++;
      if (valid && err) both_seen++;
   end

   function automatic logic [7:0] glyph(input int n);
      case (n)
         0:  return 8'h3F;
         1:  return 8'h06;
         2:  return 8'h5B;
         3:  return 8'h4F;
         4:  return 8'h66;
         5:  return 8'h6D;
         6:  return 8'h7D;
         7:  return 8'h07;
         8:  return 8'h7F;
         9:  return 8'h6F;
         10: return 8'h77;
         11: return 8'h7C;
         12: return 8'h39;
         13: return 8'h5E;
         14: return 8'h79;
         15: return 8'h71;
         default: return 8'h00;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic [5:0] d, input logic [7:0] s);
      @(negedge clk);
      dig = d;
      seg = s;
   endtask

   // Called right after driving the completing digit: valid is due two edges later.
   task automatic expect_byte(input logic [7:0] b);
      out_t e;
      e.data    = b;
      e.changed = (b != model_data);
      e.cyc     = cyc + 2;
      model_data = b;
      exp_q.push_back(e);
   endtask

   task automatic drain(input string tag);
      int n_exp;
      repeat (4) @(negedge clk);
      n_exp = exp_q.size();
      for (int i = 0; i < n_exp; i++) begin
         exp_e = exp_q[i];
         check({tag, " valid present"}, 32'(obs_q.size() > obs_rd), 32'd1);
         if (obs_q.size() > obs_rd) begin
            obs_o = obs_q[obs_rd];
            obs_rd++;
            check({tag, " data"}, 32'(obs_o.data), 32'(exp_e.data));
            check({tag, " changed"}, 32'(obs_o.changed), 32'(exp_e.changed));
            check({tag, " latency"}, 32'(obs_o.cyc), 32'(exp_e.cyc));
         end
      end
      exp_q.delete();
      check({tag, " no extra valid"}, 32'(obs_q.size() - obs_rd), 32'd0);
      obs_rd = obs_q.size();
   endtask

   initial begin
      rst_n = 1'b0;
      dig   = D_BLANK;
      seg   = 8'h00;

      // Reset with random bus activity
      repeat (3) begin
         @(negedge clk);
         seg = 8'($urandom);
         dig = 6'($urandom);
      end
      check("rst data", 32'(data), 32'h00);
      check("rst valid", 32'(valid), 32'd0);
      check("rst changed", 32'(changed), 32'd0);
      check("rst err", 32'(err), 32'd0);
      check("rst err_cnt", 32'(err_cnt), 32'd0);
      check("rst stale", 32'(stale), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dig   = D_BLANK;
      seg   = 8'h00;

      // Basic capture, blanks in between (one blank carries garbage segments)
      err0 = err_seen;
      drive(D_LO, glyph(5));
      drive(D_BLANK, 8'hFF);
      drive(D_HI, glyph(10));
      expect_byte(8'hA5);
      drive(D_BLANK, 8'h00);
      drive(D_LO, glyph(5));
      drive(D_BLANK, 8'h00);
      drive(D_HI, glyph(10));
      expect_byte(8'hA5);
      drive(D_BLANK, 8'h00);
      drain("basic");
      check("basic o_data", 32'(data), 32'hA5);
      check("basic no err", 32'(err_seen - err0), 32'd0);

      // Glyph errors: blank pattern, then lit decimal point
      err0 = err_seen;
      drive(D_LO, glyph(0));
      drive(D_HI, 8'h00);
      drive(D_BLANK, 8'h00);
      drain("glyph err");
      check("glyph err pulses", 32'(err_seen - err0), 32'd1);
      check("glyph err_cnt", 32'(err_cnt), 32'd1);
      drive(D_LO, glyph(1));
      drive(D_HI, glyph(15));
      expect_byte(8'hF1);
      drive(D_BLANK, 8'h00);
      drive(D_LO, glyph(1) | 8'h80);
      drive(D_BLANK, 8'h00);
      drain("glyph recover");
      check("glyph dp err_cnt", 32'(err_cnt), 32'd2);

      // Bad digit select mid-frame discards the stored LO nibble
      err0 = err_seen;
      drive(D_LO, glyph(2));
      drive(6'b000011, glyph(3));
      drive(D_HI, glyph(1));
      drive(D_LO, glyph(3));
      expect_byte(8'h13);
      drive(D_BLANK, 8'h00);
      drain("baddig");
      check("baddig pulses", 32'(err_seen - err0), 32'd1);
      check("baddig err_cnt", 32'(err_cnt), 32'd3);

      // Error counter saturation
      err0 = err_seen;
      for (int i = 0; i < 300; i++) begin
         drive(bad_digs[i % 4], glyph(i % 16));
      end
      drive(D_BLANK, 8'h00);
      drain("saturate");
      check("saturate pulses", 32'(err_seen - err0), 32'd300);
      check("saturate err_cnt", 32'(err_cnt), 32'd255);
      check("stale after errors", 32'(stale), 32'd1);
      drive(D_LO, glyph(0));
      drive(D_HI, glyph(0));
      expect_byte(8'h00);
      drive(D_BLANK, 8'h00);
      drain("stale clear");
      check("stale cleared by valid", 32'(stale), 32'd0);

      // Stale: partial LO is dropped once the bus goes idle
      drive(D_LO, glyph(7));
      repeat (8) drive(D_BLANK, 8'h00);
      check("stale early", 32'(stale), 32'd0);
      repeat (12) drive(D_BLANK, 8'h00);
      check("stale set", 32'(stale), 32'd1);
      drive(D_HI, glyph(1));
      repeat (2) drive(D_BLANK, 8'h00);
      check("stale held until valid", 32'(stale), 32'd1);
      drive(D_LO, glyph(12));
      expect_byte(8'h1C);
      drive(D_BLANK, 8'h00);
      drain("stale");
      check("stale final", 32'(stale), 32'd0);

      // Reset mid-frame
      drive(D_LO, glyph(3));
      @(negedge clk);
      rst_n = 1'b0;
      dig   = D_BLANK;
      seg   = 8'h00;
      repeat (2) @(negedge clk);
      check("midrst data", 32'(data), 32'h00);
      check("midrst err_cnt", 32'(err_cnt), 32'd0);
      rst_n = 1'b1;
      model_data = 8'h00;
      drive(D_HI, glyph(4));
      drive(D_LO, glyph(2));
      expect_byte(8'h42);
      drive(D_BLANK, 8'h00);
      drain("midrst");
      check("midrst o_data", 32'(data), 32'h42);

      check("valid and err overlap", 32'(both_seen), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seg_capture.md
# seg_capture

Receive-side counterpart of the two-digit multiplexed seven-segment driver: watches the scanned segment/digit-select bus and reconstructs the 8-bit hex value being displayed. Used for on-board loopback self-test of the display path and as the scoreboard front end in display-level benches. It sits beside the display driver on the same clock and observes its SEG/DIG outputs.

## Interface
- `TIMEOUT`, 1024: number of cycles without an accepted digit before `o_stale` asserts. Range 2..65535.
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_seg`  in  8  segment bus, active-high. Bit 0 = a … bit 6 = g, bit 7 = dp.
- `i_dig`  in  6  digit select, active-high one-hot. `6'b000010` = low nibble; `6'b000001` = high nibble; `6'b000000` = blank.
- `o_data`  out  8  last fully reconstructed byte, `{hi, lo}`.
- `o_valid`  out  1  one-cycle pulse when `o_data` updates.
- `o_changed`  out  1  one-cycle pulse, coincident with `o_valid`, when the new byte differs from the previous `o_data`.
- `o_err`  out  1  one-cycle pulse on a protocol or glyph error.
- `o_err_cnt`  out  8  saturating error count; stops at 255.
- `o_stale`  out  1  level; high while the bus is stale (see Operation).

## Operation
- **Stage 1.** `i_seg` and `i_dig` are registered every cycle.
- **Stage 2, digit classification** (on the registered values):
  - LO: `dig == 000010`.
  - HI: `dig == 000001`.
  - BLANK: `dig == 0`. Ignored entirely: no state change, and the timeout counter is not reset.
  - Any other value is BADDIG.
- **Glyph decode** of `seg`: dp must be 0 and `seg[6:0]` must be exactly one of 0x3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71, mapping to nibbles 0..F. Anything else is BADGLYPH.
- **FSM states:** EMPTY, GOT_LO, GOT_HI. Nibble holding registers `lo_q` and `hi_q`.
  - EMPTY + good LO → store `lo_q`, go to GOT_LO.
  - EMPTY + good HI → store `hi_q`, go to GOT_HI.
  - GOT_LO + good LO → overwrite `lo_q`, stay.
  - GOT_LO + good HI → emit `{hi, lo_q}`, go to EMPTY.
  - GOT_HI is symmetric: good HI overwrites; good LO emits `{hi_q, lo}`.
  - BADDIG, or BADGLYPH on a LO/HI cycle (from any state) → pulse `o_err`, increment `o_err_cnt` (saturating), discard the partial byte, go to EMPTY. A BADGLYPH on a BLANK cycle is not checked.
- **Emit:** `o_data` is loaded, `o_valid` pulses, and `o_changed` pulses if the new byte differs from the old `o_data`.
- **Timeout:**
  - A 16-bit counter clears on every good LO/HI and otherwise increments, saturating at `TIMEOUT`.
  - Reaching `TIMEOUT` sets `o_stale` and forces the FSM to EMPTY.
  - `o_stale` clears on the next `o_valid`.
- **Reset values:** `o_data = 0`, `o_valid = 0`, `o_changed = 0`, `o_err = 0`, `o_err_cnt = 0`, `o_stale = 0`, FSM = EMPTY, counter = 0, `lo_q = hi_q = 0`. Reset mid-frame discards any partial byte.
- **First emit after reset:** `o_changed` is computed against `o_data = 0`, so an emitted 0x00 gives no `o_changed`.

## Timing
- The bus is sampled on edge k. The completing digit is decoded and `o_data`/`o_valid` are registered on edge k+1.
- Latency is 2 edges from the completing digit appearing on the inputs to `o_valid` high. Throughput is one byte per 2 non-blank digit cycles.
- Strict alternation LO,HI,LO,HI… emits on every second digit. The pairs are (LO,HI), (LO,HI)… or (HI,LO)…, depending on which digit is seen first after EMPTY.
- `o_err` and `o_valid` are never high in the same cycle.
- Timeout and a good digit in the same cycle: the good digit wins; the counter clears and `o_stale` does not set.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `seg_pkg` holds:
  - the 16 glyph constants (active-high `[6:0]`);
  - the `DIG_LO`/`DIG_HI`/`DIG_BLANK` constants;
  - the FSM state encoding;
  - function `glyph_to_nibble` returning `{ok, nibble[3:0]}`.
- The display driver and this block both take their glyph tables from `seg_pkg`.
- Sub-module: `seg_glyph_dec`, a combinational 8-bit → `{ok, nibble}` decoder wrapping the function, instantiated once.

## Test plan
- **Reset:** hold `i_rst_n = 0` for 3 cycles with random bus activity → all outputs 0, `o_err_cnt = 0`.
- **Basic capture:** LO 0x6D, HI 0x77, alternating with BLANK cycles → `o_data = 0xA5`, one `o_valid` 2 edges after HI, `o_changed = 1`. Repeat → `o_valid` pulses again with `o_changed = 0`.
- **Glyph error:** LO 0x3F, then HI 0x00 → `o_err` pulse, `o_err_cnt = 1`, no `o_valid`. Next LO 0x06, HI 0x71 → `o_data = 0xF1`.
- **Bad digit select:** DIG 000011 mid-frame → `o_err`, partial discarded. 300 errors → `o_err_cnt` holds at 255.
- **Stale:** `TIMEOUT = 16`, BLANK only for 16 cycles → `o_stale = 1`, FSM = EMPTY. A good LO+HI pair clears `o_stale` with the `o_valid` pulse.
- **Reset mid-frame:** reset after LO 0x4F only → no emit. After release, HI 0x66 then LO 0x5B → `o_data = 0x42`.
